// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Power-up and recovery sequencer for the general-purpose PLL. It pulses
//   the PLL reset and waits for lock, with a timeout and a bounded number of
//   retries. Lock must be held stable before the downstream reset is
//   released. When lock is lost, the downstream reset drops and the PLL is
//   restarted.
//   Everything runs on the PLL reference clock, so the sequencer keeps
//   working while the PLL output is dead.
//
// Ports
//   refclk      in   reference clock; the only clock
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock flag; asynchronous, synchronised internally
//   restart     in   single-cycle request to re-run the whole sequence
//   pll_rst     out  active-high reset to the PLL
//   sys_rst_n   out  active-low downstream reset (refclk domain)
//   ready       out  PLL locked and qualified
//   fault       out  retries exhausted; sticky until restart or rst_n
//   retry_cnt   out  failed lock attempts in the current sequence
//   loss_cnt    out  lock losses seen while running; saturates at 255
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // One shared counter serves every timed state, so it is sized for the
  // longest interval of the three.
  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int CNT_MAX = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    PRST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;

  // Two-flop synchroniser. The FSM only ever looks at lock_s, never at the
  // raw pll_locked input.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer. Outputs are registered and are updated on the same edge as
  // the state change, so each output always matches the state it describes.
  // restart takes priority over everything except rst_n.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
    end else if (restart) begin
      state     <= PRST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      case (state)
        PRST: begin
          if (cnt == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt       <= '0;
            pll_rst   <= 1'b1;
            retry_cnt <= retry_cnt + 4'd1;
            if (retry_cnt == RETRY_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= PRST;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Any dropout during qualification sends the sequence back to wait
        // for lock with a fresh timeout. This is not counted as a retry.
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            ready     <= 1'b1;
            sys_rst_n <= 1'b1;
            retry_cnt <= 4'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state     <= PRST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            sys_rst_n <= 1'b0;
            if (loss_cnt != 8'hFF) begin
              loss_cnt <= loss_cnt + 8'd1;
            end
          end
        end

        FAULT: begin
          pll_rst   <= 1'b1;
          fault     <= 1'b1;
          ready     <= 1'b0;
          sys_rst_n <= 1'b0;
        end

        default: begin
          state     <= PRST;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          ready     <= 1'b0;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed sequence with randomised lock delays, checked against timings
//   derived from the sequencer's rules: pulse length, timeout length,
//   qualification latency, retry and loss bookkeeping, restart priority and
//   asynchronous reset behaviour.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE_CYC    = 4;
  localparam int LOCK_TIMEOUT_CYC = 32;
  localparam int LOCK_STABLE_CYC  = 8;
  localparam int MAX_RETRY        = 2;
  // Edges from the input change to ready: synchroniser + qualification + one.
  localparam int LAT_NOM          = 2 + LOCK_STABLE_CYC + 1;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int assert_count = 0;
  int fail_count   = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
    .MAX_RETRY       (MAX_RETRY)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #4 refclk = ~refclk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge refclk);
  endtask

  task automatic apply_stimulus(input logic lock_v, input logic restart_v);
    pll_locked = lock_v;
    restart    = restart_v;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_range(input string tag, input int observed,
                             input int lo, input int hi);
    assert_count++;
    assert (observed >= lo && observed <= hi) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    end
  endtask

  function automatic logic sel_value(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return ready;
      default: return fault;
    endcase
  endfunction

  // Counts negedges until the selected output reaches the level; an expired
  // budget counts as a failure.
  task automatic wait_level(input string tag, input int sel, input logic level,
                            input int budget, output int n);
    n = 0;
    while (sel_value(sel) !== level && n < budget) begin
      tick();
      n++;
    end
    assert_count++;
    assert (sel_value(sel) === level) else begin
      fail_count++;
      $error("[TB] FAIL %s_wait: observed=no change in %0d cycles expected=level %0d",
             tag, n, level);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pll_rst"},   pll_rst,   1);
    check_output({tag, "_sys_rst_n"}, sys_rst_n, 0);
    check_output({tag, "_ready"},     ready,     0);
    check_output({tag, "_fault"},     fault,     0);
    check_output({tag, "_retry_cnt"}, retry_cnt, 0);
    check_output({tag, "_loss_cnt"},  loss_cnt,  0);
  endtask

  initial begin
    int n;
    int d;
    int bad;
    int loss_model;

    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    ticks(3);
    check_reset_outputs("por");

    // Release reset, lock after a random delay, reach ready.
    $display("[TB] power-up sequence");
    rst_n = 1'b1;
    wait_level("s1_pulse", 0, 1'b0, 50, n);
    check_output("s1_pulse_len", n, RST_PULSE_CYC);
    d = int'($urandom_range(5, 15));
    ticks(d);
    check_output("s1_no_early_ready", ready, 0);
    apply_stimulus(1'b1, 1'b0);
    wait_level("s1_ready", 1, 1'b1, 60, n);
    check_range("s1_ready_latency", n, LAT_NOM - 1, LAT_NOM + 1);
    check_output("s1_sys_rst_n", sys_rst_n, 1);
    check_output("s1_retry_cnt", retry_cnt, 0);
    check_output("s1_pll_rst", pll_rst, 0);

    // Loss of lock in RUN for exactly the time it takes ready to fall.
    $display("[TB] loss of lock in run");
    loss_model = 0;
    ticks(int'($urandom_range(1, 5)));
    apply_stimulus(1'b0, 1'b0);
    wait_level("s5_ready_fall", 1, 1'b0, 10, n);
    check_range("s5_ready_fall_edges", n, 1, 3);
    check_output("s5_sys_rst_n", sys_rst_n, 0);
    check_output("s5_pll_rst", pll_rst, 1);
    loss_model = loss_model + 1;
    check_output("s5_loss_cnt", loss_cnt, loss_model);
    apply_stimulus(1'b1, 1'b0);
    wait_level("s5_repulse", 0, 1'b0, 20, n);
    check_output("s5_repulse_len", n, RST_PULSE_CYC);
    // Lock is already present when waiting starts: one edge to enter
    // qualification, then the qualification window.
    wait_level("s5_relock", 1, 1'b1, 40, n);
    check_output("s5_relock_latency", n, LOCK_STABLE_CYC + 1);

    // Many more losses; the counter must saturate.
    for (int i = 0; i < 256; i++) begin
      ticks(int'($urandom_range(0, 3)));
      apply_stimulus(1'b0, 1'b0);
      wait_level("s5_loop_fall", 1, 1'b0, 10, n);
      apply_stimulus(1'b1, 1'b0);
      loss_model = (loss_model < 255) ? loss_model + 1 : 255;
      check_output("s5_loop_loss_cnt", loss_cnt, loss_model);
      wait_level("s5_loop_rise", 1, 1'b1, 40, n);
    end
    check_output("s5_loss_saturated", loss_cnt, 255);

    // Restart from RUN, then a dropout during qualification.
    $display("[TB] dropout during qualification");
    apply_stimulus(1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0);
    check_output("s4_restart_ready", ready, 0);
    check_output("s4_restart_sys_rst_n", sys_rst_n, 0);
    check_output("s4_restart_pll_rst", pll_rst, 1);
    check_output("s4_restart_loss_kept", loss_cnt, 255);
    wait_level("s4_pulse", 0, 1'b0, 20, n);
    check_output("s4_pulse_len", n, RST_PULSE_CYC);
    ticks(int'($urandom_range(2, 10)));
    apply_stimulus(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready !== 1'b0 || pll_rst !== 1'b0) bad++;
    end
    apply_stimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ready !== 1'b0 || pll_rst !== 1'b0) bad++;
    end
    apply_stimulus(1'b1, 1'b0);
    check_output("s4_no_ready_in_dropout", bad, 0);
    wait_level("s4_ready", 1, 1'b1, 60, n);
    check_range("s4_ready_latency", n, LAT_NOM - 1, LAT_NOM + 1);
    check_output("s4_retry_cnt", retry_cnt, 0);

    // No lock at all: two timeouts, then FAULT.
    $display("[TB] lock timeouts");
    apply_stimulus(1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0);
    wait_level("s2_pulse1", 0, 1'b0, 20, n);
    check_output("s2_pulse1_len", n, RST_PULSE_CYC);
    wait_level("s2_timeout1", 0, 1'b1, 60, n);
    check_output("s2_timeout1_len", n, LOCK_TIMEOUT_CYC);
    check_output("s2_retry1", retry_cnt, 1);
    check_output("s2_fault_not_yet", fault, 0);
    wait_level("s2_pulse2", 0, 1'b0, 20, n);
    check_output("s2_pulse2_len", n, RST_PULSE_CYC);
    wait_level("s2_timeout2", 0, 1'b1, 60, n);
    check_output("s2_timeout2_len", n, LOCK_TIMEOUT_CYC);
    check_output("s2_fault", fault, 1);
    check_output("s2_retry2", retry_cnt, MAX_RETRY);
    check_output("s2_fault_ready", ready, 0);
    check_output("s2_fault_sys_rst_n", sys_rst_n, 0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pll_rst !== 1'b1 || fault !== 1'b1 || retry_cnt !== 4'(MAX_RETRY)) bad++;
    end
    check_output("s2_fault_held", bad, 0);

    // Restart out of FAULT and lock normally.
    $display("[TB] restart from fault");
    apply_stimulus(1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0);
    check_output("s3_fault_cleared", fault, 0);
    check_output("s3_retry_cleared", retry_cnt, 0);
    check_output("s3_pll_rst", pll_rst, 1);
    wait_level("s3_pulse", 0, 1'b0, 20, n);
    check_output("s3_pulse_len", n, RST_PULSE_CYC);
    ticks(int'($urandom_range(3, 12)));
    apply_stimulus(1'b1, 1'b0);
    wait_level("s3_ready", 1, 1'b1, 60, n);
    check_range("s3_ready_latency", n, LAT_NOM - 1, LAT_NOM + 1);
    check_output("s3_sys_rst_n", sys_rst_n, 1);
    check_output("s3_fault", fault, 0);

    // Asynchronous reset while running, away from any clock edge.
    $display("[TB] async reset and restart priority");
    ticks(2);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("s6_run_rst");
    apply_stimulus(1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    wait_level("s6_pulse", 0, 1'b0, 20, n);
    check_output("s6_pulse_len", n, RST_PULSE_CYC);

    // Restart on the same edge as a timeout: restart wins.
    ticks(LOCK_TIMEOUT_CYC - 1);
    check_output("s6_still_waiting", pll_rst, 0);
    apply_stimulus(1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0);
    check_output("s6_collide_retry", retry_cnt, 0);
    check_output("s6_collide_pll_rst", pll_rst, 1);
    check_output("s6_collide_fault", fault, 0);
    wait_level("s6_pulse2", 0, 1'b0, 20, n);
    check_output("s6_pulse2_len", n, RST_PULSE_CYC);
    wait_level("s6_timeout", 0, 1'b1, 60, n);
    check_output("s6_timeout_len", n, LOCK_TIMEOUT_CYC);
    check_output("s6_one_retry", retry_cnt, 1);
    check_output("s6_no_fault", fault, 0);

    // Asynchronous reset during qualification.
    wait_level("s6_pulse3", 0, 1'b0, 20, n);
    ticks(int'($urandom_range(2, 6)));
    apply_stimulus(1'b1, 1'b0);
    ticks(5);
    check_output("s6_stable_pll_rst", pll_rst, 0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("s6_stable_rst");
    tick();
    rst_n = 1'b1;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
